// File: rtl/reg_writeback_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback_queue_if
// Description : Bundle of retire-side handshakes, register file write port,
//               forwarding lookups and occupancy status for the writeback
//               queue. Slave modport is the queue, master is the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_writeback_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int AW    = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            wb0_valid;
  logic [AW-1:0]   wb0_rd;
  logic [XLEN-1:0] wb0_data;
  logic            wb0_ready;
  logic            wb1_valid;
  logic [AW-1:0]   wb1_rd;
  logic [XLEN-1:0] wb1_data;
  logic            wb1_ready;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] write_data;
  logic            reg_write;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            fwd1_hit;
  logic [XLEN-1:0] fwd1_data;
  logic            fwd2_hit;
  logic [XLEN-1:0] fwd2_data;
  logic [CW-1:0]   wbq_count;
  logic            wbq_full;

  modport slave (
    input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data, rs1, rs2,
    output wb0_ready, wb1_ready, rd, write_data, reg_write,
           fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, wbq_count, wbq_full
  );

  modport master (
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data, rs1, rs2,
    input  wb0_ready, wb1_ready, rd, write_data, reg_write,
           fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, wbq_count, wbq_full
  );
endinterface
`default_nettype wire

// File: rtl/reg_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback_queue
// Description : In-order writeback FIFO between MEM/WB and the register file.
//               Accepts up to two retiring results per cycle (wb0 older),
//               drains one per cycle into the register file write port and
//               forwards the youngest pending value for rs1/rs2.
//               Optional macro WBQ_COALESCE_EN merges a result into a pending
//               non-head entry with the same destination register.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_writeback_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [AW-1:0]   r_ent_rd   [DEPTH];
  logic [XLEN-1:0] r_ent_data [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic [CW-1:0]   w_free;
  logic            w_ready0;
  logic            w_ready1;
  logic            w_store0;
  logic            w_store1;
  logic            w_pop;
  logic            w_new0;
  logic            w_new1;
  logic [PW-1:0]   w_wr0_idx;
  logic [PW-1:0]   w_wr1_idx;

  // Credit is taken from occupancy at the start of the cycle; the drain
  // happening on the same edge does not free a slot for this cycle's inputs.
  assign w_free   = C_DEPTH - r_count;
  assign w_ready0 = (w_free >= CW'(1));
  assign w_ready1 = bus.wb0_valid ? (w_free >= CW'(2)) : (w_free >= CW'(1));
  assign w_store0 = bus.wb0_valid && w_ready0 && (bus.wb0_rd != '0);
  assign w_store1 = bus.wb1_valid && w_ready1 && (bus.wb1_rd != '0);
  assign w_pop    = (r_count != '0);

  assign bus.wb0_ready  = w_ready0;
  assign bus.wb1_ready  = w_ready1;
  assign bus.reg_write  = w_pop;
  assign bus.rd         = w_pop ? r_ent_rd[r_head]   : '0;
  assign bus.write_data = w_pop ? r_ent_data[r_head] : '0;
  assign bus.wbq_count  = r_count;
  assign bus.wbq_full   = (r_count == C_DEPTH);

`ifdef WBQ_COALESCE_EN
  logic          w_m0_hit;
  logic          w_m1_hit;
  logic [PW-1:0] w_m0_idx;
  logic [PW-1:0] w_m1_idx;

  // Find a pending non-head entry already targeting each incoming rd.
  always_comb begin
    w_m0_hit = 1'b0;
    w_m1_hit = 1'b0;
    w_m0_idx = '0;
    w_m1_idx = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (CW'(i) < r_count) begin
        if (r_ent_rd[r_head + PW'(i)] == bus.wb0_rd) begin
          w_m0_hit = 1'b1;
          w_m0_idx = r_head + PW'(i);
        end
        if (r_ent_rd[r_head + PW'(i)] == bus.wb1_rd) begin
          w_m1_hit = 1'b1;
          w_m1_idx = r_head + PW'(i);
        end
      end
    end
  end

  // Slot selection: merge into a matching entry, else allocate at the tail;
  // a wb1 carrying wb0's rd lands on wb0's slot so wb1_data survives.
  always_comb begin
    w_new0    = w_store0;
    w_wr0_idx = r_tail;
    if (w_store0 && w_m0_hit) begin
      w_new0    = 1'b0;
      w_wr0_idx = w_m0_idx;
    end
    w_new1    = w_store1;
    w_wr1_idx = r_tail + PW'(w_new0);
    if (w_store1 && w_store0 && (bus.wb1_rd == bus.wb0_rd)) begin
      w_new1    = 1'b0;
      w_wr1_idx = w_wr0_idx;
    end else if (w_store1 && w_m1_hit) begin
      w_new1    = 1'b0;
      w_wr1_idx = w_m1_idx;
    end
  end
`else
  // Slot selection: every stored result takes the next tail slot, wb0 first.
  always_comb begin
    w_new0    = w_store0;
    w_wr0_idx = r_tail;
    w_new1    = w_store1;
    w_wr1_idx = r_tail + PW'(w_new0);
  end
`endif

  // Forwarding: scan head to tail so the youngest matching entry wins.
  always_comb begin
    bus.fwd1_hit  = 1'b0;
    bus.fwd1_data = '0;
    bus.fwd2_hit  = 1'b0;
    bus.fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_count) begin
        if ((bus.rs1 != '0) && (r_ent_rd[r_head + PW'(i)] == bus.rs1)) begin
          bus.fwd1_hit  = 1'b1;
          bus.fwd1_data = r_ent_data[r_head + PW'(i)];
        end
        if ((bus.rs2 != '0) && (r_ent_rd[r_head + PW'(i)] == bus.rs2)) begin
          bus.fwd2_hit  = 1'b1;
          bus.fwd2_data = r_ent_data[r_head + PW'(i)];
        end
      end
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at power-of-2 DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_new0) + PW'(w_new1);
      r_count <= r_count + CW'(w_new0) + CW'(w_new1) - CW'(w_pop);
    end
  end

  // Entry storage; validity is implied by occupancy so no reset is needed.
  // wb1 is written last so it wins when both target the same slot.
  always_ff @(posedge clk) begin
    if (w_store0) begin
      r_ent_rd[w_wr0_idx]   <= bus.wb0_rd;
      r_ent_data[w_wr0_idx] <= bus.wb0_data;
    end
    if (w_store1) begin
      r_ent_rd[w_wr1_idx]   <= bus.wb1_rd;
      r_ent_data[w_wr1_idx] <= bus.wb1_data;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_writeback_queue
// Description : Self-checking bench for reg_writeback_queue: directed vector
//               table, hand-written corner sequences (full, reset mid-drain)
//               and randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_queue;
`ifdef WBQ_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  reg_writeback_queue_if #(.DEPTH(4), .XLEN(64), .AW(5)) bus ();
  reg_writeback_queue_if #(.DEPTH(2), .XLEN(64), .AW(5)) bus2 ();

  reg_writeback_queue #(.DEPTH(4), .XLEN(64), .AW(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  reg_writeback_queue #(.DEPTH(2), .XLEN(64), .AW(5)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;  logic [4:0] rd0; logic [63:0] d0;
    logic        v1;  logic [4:0] rd1; logic [63:0] d1;
    logic [4:0]  rs1; logic [4:0] rs2;
    logic        e_r0; logic e_r1; logic e_rw;
    logic [4:0]  e_rd; logic [63:0] e_wd; logic [2:0] e_cnt;
    logic        e_h1; logic [63:0] e_d1; logic e_h2; logic [63:0] e_d2;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } entry_t;

  vec_t   vt[18];
  entry_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic v0, input logic [4:0] rd0, input logic [63:0] d0,
    input logic v1, input logic [4:0] rd1, input logic [63:0] d1,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic r0, input logic r1, input logic rw, input logic [4:0] erd,
    input logic [63:0] ewd, input logic [2:0] cnt,
    input logic h1, input logic [63:0] ed1, input logic h2, input logic [63:0] ed2);
    vec_t v;
    v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
    v.rs1 = rs1; v.rs2 = rs2; v.e_r0 = r0; v.e_r1 = r1; v.e_rw = rw;
    v.e_rd = erd; v.e_wd = ewd; v.e_cnt = cnt;
    v.e_h1 = h1; v.e_d1 = ed1; v.e_h2 = h2; v.e_d2 = ed2;
    return v;
  endfunction

  task automatic drive(input logic v0, input logic [4:0] rd0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [63:0] d1,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.wb0_valid = v0; bus.wb0_rd = rd0; bus.wb0_data = d0;
    bus.wb1_valid = v1; bus.wb1_rd = rd1; bus.wb1_data = d1;
    bus.rs1 = rs1; bus.rs2 = rs2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: check outputs against the pending queue, then compute
  // the queue after this cycle's edge.
  task automatic model_cycle();
    int n, free, hit, new0;
    logic r0, r1, a0, a1, h1, h2;
    logic [63:0] d1, d2;
    entry_t nq[$];
    entry_t e;
    n = mq.size();
    free = 4 - n;
    r0 = (free >= 1);
    r1 = bus.wb0_valid ? (free >= 2) : (free >= 1);
    h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
    for (int i = 0; i < n; i++) begin
      if (bus.rs1 != 0 && mq[i].rd == bus.rs1) begin h1 = 1'b1; d1 = mq[i].data; end
      if (bus.rs2 != 0 && mq[i].rd == bus.rs2) begin h2 = 1'b1; d2 = mq[i].data; end
    end
    chk("rnd_wb0_ready", bus.wb0_ready, r0);
    chk("rnd_wb1_ready", bus.wb1_ready, r1);
    chk("rnd_reg_write", bus.reg_write, n != 0);
    if (n != 0) begin
      chk("rnd_rd", bus.rd, mq[0].rd);
      chk("rnd_write_data", bus.write_data, mq[0].data);
    end else begin
      chk("rnd_rd", bus.rd, 0);
      chk("rnd_write_data", bus.write_data, 0);
    end
    chk("rnd_count", bus.wbq_count, n);
    chk("rnd_full", bus.wbq_full, n == 4);
    chk("rnd_fwd1_hit", bus.fwd1_hit, h1);
    chk("rnd_fwd1_data", bus.fwd1_data, d1);
    chk("rnd_fwd2_hit", bus.fwd2_hit, h2);
    chk("rnd_fwd2_data", bus.fwd2_data, d2);

    a0 = bus.wb0_valid & r0;
    a1 = bus.wb1_valid & r1;
    nq = mq;
    new0 = -1;
    if (a0 && bus.wb0_rd != 0) begin
      hit = -1;
      if (COAL) for (int i = 1; i < n; i++) if (nq[i].rd == bus.wb0_rd) hit = i;
      if (hit >= 0) begin
        e = nq[hit]; e.data = bus.wb0_data; nq[hit] = e;
      end else begin
        e.rd = bus.wb0_rd; e.data = bus.wb0_data; nq.push_back(e);
        new0 = nq.size() - 1;
      end
    end
    if (a1 && bus.wb1_rd != 0) begin
      hit = -1;
      if (COAL) begin
        for (int i = 1; i < n; i++) if (nq[i].rd == bus.wb1_rd) hit = i;
        if (hit < 0 && new0 >= 0 && bus.wb0_rd == bus.wb1_rd) hit = new0;
      end
      if (hit >= 0) begin
        e = nq[hit]; e.data = bus.wb1_data; nq[hit] = e;
      end else begin
        e.rd = bus.wb1_rd; e.data = bus.wb1_data; nq.push_back(e);
      end
    end
    if (n != 0) void'(nq.pop_front());
    mq = nq;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    reset  = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus2.wb0_valid = 0; bus2.wb0_rd = 0; bus2.wb0_data = 0;
    bus2.wb1_valid = 0; bus2.wb1_rd = 0; bus2.wb1_data = 0;
    bus2.rs1 = 0; bus2.rs2 = 0;

    //         v0 rd0 d0     v1 rd1 d1    rs1 rs2 r0 r1 rw rd  wd                  cnt                h1 d1                 h2 d2
    vt[0]  = mk(0, 0, 0,     0, 0, 0,     0, 0,   1, 1, 0, 0,  0,                  0,                 0, 0,                 0, 0);
    vt[1]  = mk(1, 5, 'h64,  0, 0, 0,     0, 0,   1, 1, 0, 0,  0,                  0,                 0, 0,                 0, 0);
    vt[2]  = mk(0, 0, 0,     0, 0, 0,     5, 0,   1, 1, 1, 5,  'h64,               1,                 1, 'h64,              0, 0);
    vt[3]  = mk(0, 0, 0,     0, 0, 0,     5, 0,   1, 1, 0, 0,  0,                  0,                 0, 0,                 0, 0);
    vt[4]  = mk(1, 0, 'hFF,  1, 3, 'h9,   3, 0,   1, 1, 0, 0,  0,                  0,                 0, 0,                 0, 0);
    vt[5]  = mk(0, 0, 0,     0, 0, 0,     3, 0,   1, 1, 1, 3,  'h9,                1,                 1, 'h9,               0, 0);
    vt[6]  = mk(0, 0, 0,     0, 0, 0,     0, 0,   1, 1, 0, 0,  0,                  0,                 0, 0,                 0, 0);
    vt[7]  = mk(1, 7, 'h11,  1, 7, 'h22,  7, 0,   1, 1, 0, 0,  0,                  0,                 0, 0,                 0, 0);
    vt[8]  = mk(0, 0, 0,     0, 0, 0,     7, 0,   1, 1, 1, 7,  COAL ? 'h22 : 'h11, COAL ? 3'd1 : 3'd2, 1, 'h22,             0, 0);
    vt[9]  = mk(0, 0, 0,     0, 0, 0,     7, 0,   1, 1, !COAL, COAL ? 5'd0 : 5'd7, COAL ? 0 : 'h22, COAL ? 3'd0 : 3'd1,
                !COAL, COAL ? 0 : 'h22, 0, 0);
    vt[10] = mk(0, 0, 0,     0, 0, 0,     0, 0,   1, 1, 0, 0,  0,                  0,                 0, 0,                 0, 0);
    vt[11] = mk(1, 1, 'hA,   1, 2, 'hB,   0, 0,   1, 1, 0, 0,  0,                  0,                 0, 0,                 0, 0);
    vt[12] = mk(1, 9, 'h1,   1, 3, 'hC,   9, 2,   1, 1, 1, 1,  'hA,                2,                 0, 0,                 1, 'hB);
    vt[13] = mk(1, 9, 'h2,   0, 0, 0,     9, 0,   1, 0, 1, 2,  'hB,                3,                 1, 'h1,               0, 0);
    vt[14] = mk(0, 0, 0,     0, 0, 0,     9, 0,   1, 1, 1, 9,  COAL ? 'h2 : 'h1,   COAL ? 3'd2 : 3'd3, 1, 'h2,              0, 0);
    vt[15] = mk(0, 0, 0,     0, 0, 0,     9, 0,   1, 1, 1, 3,  'hC,                COAL ? 3'd1 : 3'd2, !COAL, COAL ? 0 : 'h2, 0, 0);
    vt[16] = mk(0, 0, 0,     0, 0, 0,     9, 0,   1, 1, !COAL, COAL ? 5'd0 : 5'd9, COAL ? 0 : 'h2, COAL ? 3'd0 : 3'd1,
                !COAL, COAL ? 0 : 'h2, 0, 0);
    vt[17] = mk(0, 0, 0,     0, 0, 0,     0, 0,   1, 1, 0, 0,  0,                  0,                 0, 0,                 0, 0);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step();

    // Directed vector table.
    for (int k = 0; k < 18; k++) begin
      drive(vt[k].v0, vt[k].rd0, vt[k].d0, vt[k].v1, vt[k].rd1, vt[k].d1, vt[k].rs1, vt[k].rs2);
      #1;
      chk($sformatf("row%0d_wb0_ready", k), bus.wb0_ready, vt[k].e_r0);
      chk($sformatf("row%0d_wb1_ready", k), bus.wb1_ready, vt[k].e_r1);
      chk($sformatf("row%0d_reg_write", k), bus.reg_write, vt[k].e_rw);
      chk($sformatf("row%0d_rd", k), bus.rd, vt[k].e_rd);
      chk($sformatf("row%0d_write_data", k), bus.write_data, vt[k].e_wd);
      chk($sformatf("row%0d_count", k), bus.wbq_count, vt[k].e_cnt);
      chk($sformatf("row%0d_full", k), bus.wbq_full, vt[k].e_cnt == 3'd4);
      chk($sformatf("row%0d_fwd1_hit", k), bus.fwd1_hit, vt[k].e_h1);
      chk($sformatf("row%0d_fwd1_data", k), bus.fwd1_data, vt[k].e_d1);
      chk($sformatf("row%0d_fwd2_hit", k), bus.fwd2_hit, vt[k].e_h2);
      chk($sformatf("row%0d_fwd2_data", k), bus.fwd2_data, vt[k].e_d2);
      step();
    end

    // Fill with pairs: occupancy saturates at 3 because a drain happens every cycle.
    drive(1, 1, 'h101, 1, 2, 'h102, 0, 0);
    #1;
    chk("fill_a_wb1_ready", bus.wb1_ready, 1);
    step();
    drive(1, 3, 'h103, 1, 4, 'h104, 0, 0);
    #1;
    chk("fill_b_count", bus.wbq_count, 2);
    chk("fill_b_rd", bus.rd, 1);
    chk("fill_b_wb1_ready", bus.wb1_ready, 1);
    step();
    drive(1, 5, 'h105, 1, 6, 'h106, 0, 0);
    #1;
    chk("fill_c_count", bus.wbq_count, 3);
    chk("fill_c_wb0_ready", bus.wb0_ready, 1);
    chk("fill_c_wb1_ready", bus.wb1_ready, 0);
    chk("fill_c_full", bus.wbq_full, 0);
    chk("fill_c_rd", bus.rd, 2);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 3; k <= 5; k++) begin
      #1;
      chk($sformatf("drain_%0d_rd", k), bus.rd, k);
      chk($sformatf("drain_%0d_data", k), bus.write_data, 64'h100 + 64'(k));
      step();
    end
    #1;
    chk("drain_done_reg_write", bus.reg_write, 0);
    step();

    // Reset low mid-drain with three pending entries.
    drive(1, 1, 'h201, 1, 2, 'h202, 0, 0);
    step();
    drive(1, 3, 'h203, 1, 4, 'h204, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_pre_count", bus.wbq_count, 3);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_async_reg_write", bus.reg_write, 0);
    chk("rst_async_count", bus.wbq_count, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("rst_next_reg_write", bus.reg_write, 0);
    chk("rst_next_count", bus.wbq_count, 0);
    chk("rst_next_rd", bus.rd, 0);
    chk("rst_next_write_data", bus.write_data, 0);
    for (int r = 0; r < 32; r++) begin
      bus.rs1 = 5'(r);
      #1;
      chk($sformatf("rst_fwd1_hit_rs%0d", r), bus.fwd1_hit, 0);
      chk($sformatf("rst_fwd1_data_rs%0d", r), bus.fwd1_data, 0);
    end
    bus.rs1 = 0;
    step();

    // DEPTH=2 instance: a pair into an empty queue reaches full.
    bus2.wb0_valid = 1; bus2.wb0_rd = 1; bus2.wb0_data = 'h11;
    bus2.wb1_valid = 1; bus2.wb1_rd = 2; bus2.wb1_data = 'h22;
    #1;
    chk("d2_pair_wb0_ready", bus2.wb0_ready, 1);
    chk("d2_pair_wb1_ready", bus2.wb1_ready, 1);
    step();
    bus2.wb0_valid = 0;
    bus2.wb1_rd = 3; bus2.wb1_data = 'h33;
    #1;
    chk("d2_full_count", bus2.wbq_count, 2);
    chk("d2_full_flag", bus2.wbq_full, 1);
    chk("d2_full_wb0_ready", bus2.wb0_ready, 0);
    chk("d2_full_wb1_ready", bus2.wb1_ready, 0);
    chk("d2_full_rd", bus2.rd, 1);
    step();
    bus2.wb1_valid = 0;
    #1;
    chk("d2_after_count", bus2.wbq_count, 1);
    chk("d2_after_full", bus2.wbq_full, 0);
    chk("d2_after_rd", bus2.rd, 2);
    chk("d2_after_data", bus2.write_data, 'h22);
    step();
    #1;
    chk("d2_empty_reg_write", bus2.reg_write, 0);
    step();

    // Randomized traffic against the reference model.
    reset = 1'b0;
    step();
    reset = 1'b1;
    mq.delete();
    step();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), {$urandom, $urandom},
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), {$urandom, $urandom},
            5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));
      #1;
      model_cycle();
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire
